// File: rtl/serial_work_transmit.sv
// Host-side serial link: sends 512-bit work packets as 64 UART 8N1 bytes
// on TxD and assembles 4-byte golden-nonce replies from RxD.
`timescale 1ns/1ps
module serial_work_transmit #(
  parameter int comm_clk_frequency = 130_000_000,
  parameter int baud_rate = 115_200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [255:0] work_midstate,
  input  logic [255:0] work_data2,
  input  logic         work_valid,
  output logic         work_ready,
  output logic         TxD,
  input  logic         RxD,
  output logic [31:0]  nonce,
  output logic         nonce_valid,
  output logic         exhausted,
  output logic         framing_error
);

  localparam int BP = comm_clk_frequency / baud_rate;
  localparam int TW = (BP > 2) ? $clog2(BP) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(BP - 1);
  localparam logic [TW-1:0] T_HALF = TW'(BP / 2);
  localparam int TO = TIMEOUT_BITS * BP;
  localparam int OW = $clog2(TO + 1);
  localparam logic [OW-1:0] O_LAST = OW'(TO - 1);

  typedef enum logic [1:0] {
    T_IDLE, T_START, T_DATA, T_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_STOP, R_WAIT
  } rx_state_t;

  tx_state_t tx_state, tx_next;
  logic [511:0] pkt;
  logic [TW-1:0] tx_tmr;
  logic [2:0] tx_bit;
  logic [5:0] tx_byte;
  logic [7:0] tx_cur;
  logic tx_tick;

  assign tx_tick = (tx_tmr == T_LAST);
  assign tx_cur = pkt[511:504];
  assign work_ready = (tx_state == T_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tx_state <= T_IDLE;
    else tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    TxD = 1'b1;
    unique case (tx_state)
      T_IDLE: begin
        if (work_valid) tx_next = T_START;
      end
      T_START: begin
        TxD = 1'b0;
        if (tx_tick) tx_next = T_DATA;
      end
      T_DATA: begin
        TxD = tx_cur[tx_bit];
        if (tx_tick && tx_bit == 3'd7) tx_next = T_STOP;
      end
      T_STOP: begin
        if (tx_tick)
          tx_next = (tx_byte == 6'd63) ? T_IDLE : T_START;
      end
      default: tx_next = T_IDLE;
    endcase
  end

  // Packet is consumed by shifting; the next byte is always pkt[511:504].
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt <= '0;
      tx_tmr <= '0;
      tx_bit <= '0;
      tx_byte <= '0;
    end else if (tx_state == T_IDLE) begin
      tx_tmr <= '0;
      tx_bit <= '0;
      tx_byte <= '0;
      if (work_valid) pkt <= {work_midstate, work_data2};
    end else begin
      tx_tmr <= tx_tick ? '0 : tx_tmr + 1'b1;
      if (tx_tick && tx_state == T_DATA) tx_bit <= tx_bit + 1'b1;
      if (tx_tick && tx_state == T_STOP) begin
        tx_byte <= (tx_byte == 6'd63) ? 6'd0 : tx_byte + 1'b1;
        pkt <= {pkt[503:0], 8'h00};
      end
    end
  end

  rx_state_t rx_state, rx_next;
  logic rx_s1, rx_s2;
  logic [TW-1:0] rx_tmr;
  logic [2:0] rx_bit;
  logic [1:0] rx_cnt;
  logic [7:0] rx_sh;
  logic [23:0] shadow;
  logic [OW-1:0] idle_cnt;
  logic rx_tick;
  logic [31:0] word;

  assign rx_tick = (rx_tmr == T_LAST);
  assign word = {rx_sh, shadow};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_state <= R_IDLE;
    end else begin
      rx_s1 <= RxD;
      rx_s2 <= rx_s1;
      rx_state <= rx_next;
    end
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      R_IDLE: if (!rx_s2) rx_next = R_START;
      R_START: begin
        if (rx_tmr == T_HALF)
          rx_next = rx_s2 ? R_IDLE : R_DATA;
      end
      R_DATA: if (rx_tick && rx_bit == 3'd7) rx_next = R_STOP;
      R_STOP: begin
        if (rx_tick)
          rx_next = rx_s2 ? R_IDLE : R_WAIT;
      end
      R_WAIT: if (rx_s2) rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_tmr <= '0;
      rx_bit <= '0;
      rx_cnt <= '0;
      rx_sh <= '0;
      shadow <= '0;
      idle_cnt <= '0;
      nonce <= '0;
      nonce_valid <= 1'b0;
      exhausted <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      nonce_valid <= 1'b0;
      exhausted <= 1'b0;
      framing_error <= 1'b0;
      idle_cnt <= '0;
      unique case (rx_state)
        R_IDLE: begin
          rx_tmr <= '0;
          rx_bit <= '0;
          // Stale partial word is dropped after a long silence.
          if (rx_cnt != 2'd0 && rx_s2) begin
            if (idle_cnt == O_LAST) rx_cnt <= '0;
            else idle_cnt <= idle_cnt + 1'b1;
          end
        end
        R_START: begin
          rx_tmr <= (rx_tmr == T_HALF) ? '0 : rx_tmr + 1'b1;
        end
        R_DATA: begin
          rx_tmr <= rx_tick ? '0 : rx_tmr + 1'b1;
          if (rx_tick) begin
            rx_sh <= {rx_s2, rx_sh[7:1]};
            rx_bit <= rx_bit + 1'b1;
          end
        end
        R_STOP: begin
          rx_tmr <= rx_tick ? '0 : rx_tmr + 1'b1;
          if (rx_tick) begin
            if (!rx_s2) begin
              framing_error <= 1'b1;
              rx_cnt <= '0;
            end else if (rx_cnt == 2'd3) begin
              nonce <= word;
              nonce_valid <= (word != 32'd0);
              exhausted <= (word == 32'd0);
              rx_cnt <= '0;
            end else begin
              unique case (rx_cnt)
                2'd0: shadow[7:0] <= rx_sh;
                2'd1: shadow[15:8] <= rx_sh;
                default: shadow[23:16] <= rx_sh;
              endcase
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
        end
        default: rx_tmr <= '0;
      endcase
    end
  end

endmodule
